// File: rtl/boron_sbox_layer.sv
// Boron S-box layer: applies the 4-bit Boron S-box (forward for encrypt,
// inverse for decrypt) to every nibble of a BLOCK_W-bit state, LANES
// nibbles per clock, with valid/ready handshakes on both sides.
module boron_sbox_layer #(
  parameter int BLOCK_W = 64,
  parameter int LANES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int NBEATS = BLOCK_W / (4 * LANES);
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_t;

  fsm_t               state;
  fsm_t               state_next;
  logic [BLOCK_W-1:0] block_q;
  logic [BLOCK_W-1:0] sub_block;
  logic [BEAT_W-1:0]  beat;
  logic               mode_q;
  logic               accept;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hA;  4'h1: y = 4'h3;  4'h2: y = 4'h9;  4'h3: y = 4'hE;
      4'h4: y = 4'h1;  4'h5: y = 4'hD;  4'h6: y = 4'hF;  4'h7: y = 4'h4;
      4'h8: y = 4'hC;  4'h9: y = 4'h5;  4'hA: y = 4'h7;  4'hB: y = 4'h2;
      4'hC: y = 4'h6;  4'hD: y = 4'h8;  4'hE: y = 4'h0;  default: y = 4'hB;
    endcase
    return y;
  endfunction

  assign accept = (state == IDLE) && in_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; no bypass from DONE straight to BUSY.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (beat == LAST_BEAT) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Substitute only the LANES nibbles selected by the current beat.
  always_comb begin
    sub_block = block_q;
    for (int l = 0; l < LANES; l++) begin
      sub_block[(int'(beat) * LANES + l) * 4 +: 4] =
        mode_q ? sbox_inv(block_q[(int'(beat) * LANES + l) * 4 +: 4])
               : sbox_fwd(block_q[(int'(beat) * LANES + l) * 4 +: 4]);
    end
  end

  // State register, beat counter and per-block mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_q <= '0;
      beat    <= '0;
      mode_q  <= 1'b0;
    end else if (accept) begin
      block_q <= in_data;
      mode_q  <= in_mode;
      beat    <= '0;
    end else if (state == BUSY) begin
      block_q <= sub_block;
      if (beat != LAST_BEAT) beat <= beat + 1'b1;
    end
  end

  assign out_data = block_q;

endmodule

// File: tb/tb_boron_sbox_layer.sv
// Directed bench for boron_sbox_layer: default instance plus three
// parameter variants (LANES=1, LANES=16, BLOCK_W=32/LANES=2) sharing inputs.
module tb_boron_sbox_layer;

  localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT   = 64'hE4B179CAD20F8536;
  localparam logic [63:0] DT   = 64'hA39E1DF4C572680B;
  // Nibble i of each table is S(i).
  localparam logic [63:0] FWD_TAB = 64'h6358F02DAC971B4E;
  localparam logic [63:0] INV_TAB = 64'hB086275C4FD1E93A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [3:0]  ir, ov, bz;
  logic [63:0] od0, od1, od2;
  logic [31:0] od3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  boron_sbox_layer #(.BLOCK_W(64), .LANES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od0), .busy(bz[0]));

  boron_sbox_layer #(.BLOCK_W(64), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od1), .busy(bz[1]));

  boron_sbox_layer #(.BLOCK_W(64), .LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[2]),
    .out_ready(out_ready), .out_data(od2), .busy(bz[2]));

  boron_sbox_layer #(.BLOCK_W(32), .LANES(2)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(in_data[31:0]), .in_mode(in_mode), .out_valid(ov[3]),
    .out_ready(out_ready), .out_data(od3), .busy(bz[3]));

  function automatic logic [63:0] ref_sub(input logic [63:0] d, input logic m,
                                          input int nibs);
    logic [63:0] t;
    logic [63:0] r;
    t = m ? INV_TAB : FWD_TAB;
    r = '0;
    for (int i = 0; i < nibs; i++) r[i*4 +: 4] = t[int'(d[i*4 +: 4]) * 4 +: 4];
    return r;
  endfunction

  function automatic logic [63:0] od_of(input int i);
    case (i)
      0:       return od0;
      1:       return od1;
      2:       return od2;
      default: return {32'h0, od3};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one block into u_dut and wait for out_valid; optionally toggle in_mode.
  task automatic do_block(input logic [63:0] d, input logic m, input bit toggle,
                          output int lat, output logic [63:0] res, output int bcnt);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (ov[0] !== 1'b1 && lat < 40) begin
      if (bz[0] === 1'b1) bcnt++;
      if (toggle) in_mode = ~in_mode;
      tick();
      lat++;
    end
    res = od0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (ir !== 4'hF) begin bad++; $display("FAIL reset_in_ready got=%b exp=1111", ir); end
    total++; if (ov !== 4'h0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0000", ov); end
    total++; if (bz !== 4'h0) begin bad++; $display("FAIL reset_busy got=%b exp=0000", bz); end
    total++; if (od0 !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", od0); end
    rst = 1'b0;
  endtask

  task automatic test_encrypt();
    int lat, bcnt;
    logic [63:0] res;
    out_ready = 1'b1;
    total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL enc_ready_before got=%b exp=1", ir[0]); end
    do_block(PT, 1'b0, 1'b0, lat, res, bcnt);
    total++; if (lat != 4) begin bad++; $display("FAIL enc_latency got=%0d exp=4", lat); end
    total++; if (res !== CT) begin bad++; $display("FAIL enc_data got=%h exp=%h", res, CT); end
    total++; if (bcnt != 4) begin bad++; $display("FAIL enc_busy_cycles got=%0d exp=4", bcnt); end
    tick();
    total++; if (ir[0] !== 1'b1 || ov[0] !== 1'b0)
      begin bad++; $display("FAIL enc_back_to_idle got ir=%b ov=%b exp ir=1 ov=0", ir[0], ov[0]); end
  endtask

  task automatic test_decrypt();
    int lat, bcnt;
    logic [63:0] res;
    out_ready = 1'b1;
    do_block(PT, 1'b1, 1'b0, lat, res, bcnt);
    total++; if (res !== DT) begin bad++; $display("FAIL dec_data got=%h exp=%h", res, DT); end
    total++; if (lat != 4) begin bad++; $display("FAIL dec_latency got=%0d exp=4", lat); end
    tick();
    do_block(CT, 1'b1, 1'b0, lat, res, bcnt);
    total++; if (res !== PT) begin bad++; $display("FAIL dec_roundtrip got=%h exp=%h", res, PT); end
    tick();
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    in_data   = PT;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    tick();
    // Junk request held high through BUSY and DONE must be ignored.
    in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    in_mode = 1'b1;
    w = 0;
    while (ov[0] !== 1'b1 && w < 40) begin tick(); w++; end
    total++; if (w != 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", w); end
    for (int c = 0; c < 5; c++) begin
      total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", c, ov[0]); end
      total++; if (od0 !== CT) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", c, od0, CT); end
      total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", c, ir[0]); end
      tick();
    end
    // Release with in_valid still high: no same-cycle acceptance.
    out_ready = 1'b1;
    tick();
    total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", ir[0]); end
    total++; if (bz[0] !== 1'b0 || ov[0] !== 1'b0)
      begin bad++; $display("FAIL bp_no_bypass got busy=%b ov=%b exp 0 0", bz[0], ov[0]); end
    in_valid = 1'b0;
  endtask

  task automatic test_mode_latch();
    int lat, bcnt;
    logic [63:0] res;
    out_ready = 1'b1;
    do_block(PT, 1'b0, 1'b1, lat, res, bcnt);
    total++; if (res !== CT) begin bad++; $display("FAIL mode_latch_data got=%h exp=%h", res, CT); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic [63:0] res;
    out_ready = 1'b1;
    in_data   = PT;
    in_mode   = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total++; if (ir[0] !== 1'b1 || bz[0] !== 1'b0)
      begin bad++; $display("FAIL midrst_state got ir=%b busy=%b exp 1 0", ir[0], bz[0]); end
    total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", ov[0]); end
    total++; if (od0 !== 64'h0) begin bad++; $display("FAIL midrst_out_data got=%h exp=0", od0); end
    rst = 1'b0;
    do_block(PT, 1'b0, 1'b0, lat, res, bcnt);
    total++; if (res !== CT || lat != 4)
      begin bad++; $display("FAIL midrst_next_block got=%h lat=%0d exp=%h lat=4", res, lat, CT); end
    tick();
  endtask

  task automatic test_param_sweep();
    int          exp_lat[4] = '{4, 16, 1, 4};
    int          nibs[4]    = '{16, 16, 16, 8};
    int          lat[4];
    logic [63:0] got[4];
    bit          seen[4];
    logic [63:0] d, e;
    int          w;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int m = 0; m < 2; m++) begin
        d = {$urandom, $urandom};
        w = 0;
        while (ir !== 4'hF && w < 40) begin tick(); w++; end
        total++; if (ir !== 4'hF) begin bad++; $display("FAIL sweep_idle_timeout got=%b exp=1111", ir); end
        in_data  = d;
        in_mode  = m[0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin seen[k] = 1'b0; lat[k] = -1; got[k] = '0; end
        for (int c = 1; c <= 30; c++) begin
          tick();
          for (int k = 0; k < 4; k++) begin
            if (!seen[k] && ov[k] === 1'b1) begin
              seen[k] = 1'b1;
              lat[k]  = c;
              got[k]  = od_of(k);
            end
          end
          if (seen[0] && seen[1] && seen[2] && seen[3]) break;
        end
        for (int k = 0; k < 4; k++) begin
          e = ref_sub(d, m[0], nibs[k]);
          total++; if (got[k] !== e)
            begin bad++; $display("FAIL sweep_data inst=%0d mode=%0d in=%h got=%h exp=%h", k, m, d, got[k], e); end
          total++; if (lat[k] != exp_lat[k])
            begin bad++; $display("FAIL sweep_latency inst=%0d got=%0d exp=%0d", k, lat[k], exp_lat[k]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_mode_latch();
    test_reset_mid();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
